carregador_programa: RTL and testbench
======================================

CARREGADOR_PROGRAMA -- requirements
Module: carregador_programa

Interface
REQ-001 SHALL have ports: Clock  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have ports: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: Iniciar  in  1  start-load request, sampled in OCIOSO/FIM_OK/FIM_ERRO.
REQ-004 SHALL have ports: ByteEntrada  in  8  incoming stream byte; ByteValido  in  1  byte present.
REQ-005 SHALL have ports: ByteAceito  out  1  loader ready; transfer = ByteValido & ByteAceito at rising edge.
REQ-006 SHALL have ports: EndInstr  out  8  instruction-memory write address; InstrEscrita  out  8  write data; EscInstr  out  1  write enable.
REQ-007 SHALL have ports: SegurarCPU  out  1  holds nRisc core in reset while high.
REQ-008 SHALL have ports: Ocupado  out  1  load in progress; Concluido  out  1  load succeeded; ErroCarga  out  1  load failed.
REQ-009 All outputs SHALL be registered.

Function
REQ-010 Stream format SHALL be: length byte N, then N instruction bytes, then checksum byte C; valid when (N + sum of data + C) mod 256 = 0.
REQ-011 FSM states SHALL be OCIOSO, TAMANHO, DADOS, CHECKSUM, LIMPA, FIM_OK, FIM_ERRO.
REQ-012 OCIOSO/FIM_OK/FIM_ERRO: Iniciar=1 -> TAMANHO; clear Concluido, ErroCarga, running sum, address counter; set SegurarCPU=1.
REQ-013 Iniciar SHALL be ignored in TAMANHO, DADOS, CHECKSUM, LIMPA.
REQ-014 ByteAceito SHALL be 1 only in TAMANHO, DADOS, CHECKSUM; 0 elsewhere.
REQ-015 TAMANHO: on transfer, N=0 -> FIM_ERRO; else latch N, sum=N, counter=0, -> DADOS.
REQ-016 DADOS: on transfer, next cycle EscInstr=1, EndInstr=counter, InstrEscrita=byte; sum += byte (8-bit wrap); counter += 1; counter reaching N -> CHECKSUM.
REQ-017 EscInstr SHALL be a one-cycle pulse per accepted data byte; back-to-back transfers give consecutive-cycle writes at consecutive addresses.
REQ-018 Cycles with ByteValido=0 SHALL not advance counter, sum or state.
REQ-019 CHECKSUM: on transfer, (sum + C) mod 256 = 0 -> LIMPA; else -> FIM_ERRO; no memory write.
REQ-020 LIMPA: write 0x00 to addresses N..255, one per cycle (EscInstr=1), 256-N cycles; after address 255 -> FIM_OK; N=255 gives exactly one clear write (address 255).
REQ-021 Address counter SHALL be 8-bit; no wrap beyond 255 in LIMPA.
REQ-022 FIM_OK: Concluido=1, SegurarCPU=0, Ocupado=0, held until Iniciar or Reset.
REQ-023 FIM_ERRO: ErroCarga=1, SegurarCPU=1, Ocupado=0, held until Iniciar or Reset; partial writes stay in memory.
REQ-024 Ocupado SHALL be 1 exactly in TAMANHO, DADOS, CHECKSUM, LIMPA.

Reset
REQ-025 Reset=1 at a rising edge SHALL force OCIOSO from any state, including mid-DADOS/LIMPA, aborting the load.
REQ-026 Reset values: ByteAceito=0, EscInstr=0, EndInstr=0x00, InstrEscrita=0x00, SegurarCPU=1, Ocupado=0, Concluido=0, ErroCarga=0, counter=0, sum=0.
REQ-027 Reset SHALL take priority over Iniciar and any transfer in the same cycle; no EscInstr pulse in the cycle after reset.

Verification
REQ-028 Good load: Iniciar; stream 0x03,0x12,0x34,0x56,0x61 back-to-back -> writes 0x12@0,0x34@1,0x56@2, then 253 zero writes @3..255, then Concluido=1, SegurarCPU=0.
REQ-029 Bad checksum: 0x03,0x12,0x34,0x56,0x60 -> 3 writes, no LIMPA writes, ErroCarga=1, SegurarCPU=1.
REQ-030 Zero length: Iniciar; 0x00 -> FIM_ERRO next cycle, no EscInstr pulse.
REQ-031 Stalled stream: good-load bytes with ByteValido=0 gaps of 1-3 cycles -> identical writes/final state as REQ-028.
REQ-032 Reset mid-DADOS after 2nd data byte -> OCIOSO, all outputs at REQ-026 values; new Iniciar + full stream completes normally.
REQ-033 Max length: N=0xFF, data 0x01 x255, C=0x02 -> 255 writes, one zero write @255, Concluido=1.

Source files
------------

// File: rtl/carregador_programa.sv
// Program loader for the nRisc instruction memory.
// Accepts a byte stream (length N, N instruction bytes, checksum C), writes the
// instructions to addresses 0..N-1, verifies (N + sum + C) mod 256 == 0, and
// on success zero-fills addresses N..255 before releasing the core.
// Ports:
//   Clock, Reset (sync, active-high), Iniciar (start request)
//   ByteEntrada/ByteValido/ByteAceito : stream handshake
//   EndInstr/InstrEscrita/EscInstr    : instruction-memory write port
//   SegurarCPU, Ocupado, Concluido, ErroCarga : status (all registered)
module carregador_programa (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Iniciar,
  input  logic [7:0] ByteEntrada,
  input  logic       ByteValido,
  output logic       ByteAceito,
  output logic [7:0] EndInstr,
  output logic [7:0] InstrEscrita,
  output logic       EscInstr,
  output logic       SegurarCPU,
  output logic       Ocupado,
  output logic       Concluido,
  output logic       ErroCarga
);

  typedef enum logic [2:0] {
    OCIOSO, TAMANHO, DADOS, CHECKSUM, LIMPA, FIM_OK, FIM_ERRO
  } estado_t;

  estado_t    state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] cnt_q, cnt_d;
  logic       byte_aceito_q, byte_aceito_d;
  logic [7:0] end_instr_q, end_instr_d;
  logic [7:0] instr_escrita_q, instr_escrita_d;
  logic       esc_instr_q, esc_instr_d;
  logic       segurar_cpu_q, segurar_cpu_d;
  logic       ocupado_q, ocupado_d;
  logic       concluido_q, concluido_d;
  logic       erro_carga_q, erro_carga_d;

  logic       transfer;
  logic [7:0] soma_final;

  // Handshake uses the registered ByteAceito so the transfer condition is
  // exactly what the source observes.
  assign transfer = ByteValido & byte_aceito_q;

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    sum_d           = sum_q;
    cnt_d           = cnt_q;
    esc_instr_d     = 1'b0;
    end_instr_d     = end_instr_q;
    instr_escrita_d = instr_escrita_q;
    soma_final      = sum_q + ByteEntrada;

    case (state_q)
      OCIOSO, FIM_OK, FIM_ERRO: begin
        if (Iniciar) begin
          state_d = TAMANHO;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      TAMANHO: begin
        if (transfer) begin
          if (ByteEntrada == '0) begin
            state_d = FIM_ERRO;
          end else begin
            len_d   = ByteEntrada;
            sum_d   = ByteEntrada;
            cnt_d   = '0;
            state_d = DADOS;
          end
        end
      end
      DADOS: begin
        if (transfer) begin
          esc_instr_d     = 1'b1;
          end_instr_d     = cnt_q;
          instr_escrita_d = ByteEntrada;
          sum_d           = soma_final;
          cnt_d           = cnt_q + 8'd1;
          if (cnt_d == len_q) state_d = CHECKSUM;
        end
      end
      CHECKSUM: begin
        if (transfer) state_d = (soma_final == '0) ? LIMPA : FIM_ERRO;
      end
      LIMPA: begin
        // Counter starts at N; it stops at 255 instead of wrapping.
        esc_instr_d     = 1'b1;
        end_instr_d     = cnt_q;
        instr_escrita_d = '0;
        if (cnt_q == '1) state_d = FIM_OK;
        else             cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = OCIOSO;
    endcase

    // Status outputs are derived from the next state so the registered copy
    // always matches the state register.
    byte_aceito_d = (state_d == TAMANHO) || (state_d == DADOS) || (state_d == CHECKSUM);
    ocupado_d     = byte_aceito_d || (state_d == LIMPA);
    concluido_d   = (state_d == FIM_OK);
    erro_carga_d  = (state_d == FIM_ERRO);
    segurar_cpu_d = (state_d != FIM_OK);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q         <= OCIOSO;
      len_q           <= '0;
      sum_q           <= '0;
      cnt_q           <= '0;
      byte_aceito_q   <= 1'b0;
      end_instr_q     <= '0;
      instr_escrita_q <= '0;
      esc_instr_q     <= 1'b0;
      segurar_cpu_q   <= 1'b1;
      ocupado_q       <= 1'b0;
      concluido_q     <= 1'b0;
      erro_carga_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      sum_q           <= sum_d;
      cnt_q           <= cnt_d;
      byte_aceito_q   <= byte_aceito_d;
      end_instr_q     <= end_instr_d;
      instr_escrita_q <= instr_escrita_d;
      esc_instr_q     <= esc_instr_d;
      segurar_cpu_q   <= segurar_cpu_d;
      ocupado_q       <= ocupado_d;
      concluido_q     <= concluido_d;
      erro_carga_q    <= erro_carga_d;
    end
  end

  assign ByteAceito   = byte_aceito_q;
  assign EndInstr     = end_instr_q;
  assign InstrEscrita = instr_escrita_q;
  assign EscInstr     = esc_instr_q;
  assign SegurarCPU   = segurar_cpu_q;
  assign Ocupado      = ocupado_q;
  assign Concluido    = concluido_q;
  assign ErroCarga    = erro_carga_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: directed loads (good, bad
// checksum, zero length, stalled, max length, reset mid-load) plus random
// streams, checked against a stream-level reference model.
module tb_carregador_programa;

  logic       Clock;
  logic       Reset;
  logic       Iniciar;
  logic [7:0] ByteEntrada;
  logic       ByteValido;
  logic       ByteAceito;
  logic [7:0] EndInstr;
  logic [7:0] InstrEscrita;
  logic       EscInstr;
  logic       SegurarCPU;
  logic       Ocupado;
  logic       Concluido;
  logic       ErroCarga;

  carregador_programa dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Iniciar     (Iniciar),
    .ByteEntrada (ByteEntrada),
    .ByteValido  (ByteValido),
    .ByteAceito  (ByteAceito),
    .EndInstr    (EndInstr),
    .InstrEscrita(InstrEscrita),
    .EscInstr    (EscInstr),
    .SegurarCPU  (SegurarCPU),
    .Ocupado     (Ocupado),
    .Concluido   (Concluido),
    .ErroCarga   (ErroCarga)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  stream[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic        exp_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every memory write seen on the port, as {address, data}.
  always @(negedge Clock) begin
    if (EscInstr === 1'b1) got_q.push_back({EndInstr, InstrEscrita});
  end

  // Reference: from the stream alone, list the expected writes and outcome.
  task automatic build_model();
    int unsigned n, s;
    exp_q.delete();
    exp_ok = 1'b0;
    n = stream[0];
    if (n != 0) begin
      s = n;
      for (int unsigned i = 1; i <= n; i++) begin
        exp_q.push_back({8'(i - 1), stream[i]});
        s = s + stream[i];
      end
      s = s + stream[n + 1];
      exp_ok = ((s % 256) == 0);
      if (exp_ok)
        for (int unsigned a = n; a <= 255; a++) exp_q.push_back({8'(a), 8'h00});
    end
  endtask

  // Called at a negedge; returns at the negedge following the transfer.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned waited;
    ByteValido = 1'b0;
    repeat (gap) @(negedge Clock);
    Iniciar     = 1'($urandom_range(0, 1));
    ByteValido  = 1'b1;
    ByteEntrada = b;
    waited = 0;
    while (!ByteAceito && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    if (!ByteAceito) check("accept_timeout", 32'(ByteAceito), 32'd1);
    @(negedge Clock);
  endtask

  task automatic start_load();
    got_q.delete();
    Iniciar = 1'b1;
    @(negedge Clock);
    Iniciar = 1'b0;
    check("start_busy", 32'(Ocupado), 32'd1);
    check("start_hold", 32'(SegurarCPU), 32'd1);
    check("start_acc", 32'(ByteAceito), 32'd1);
    check("start_done_clr", 32'(Concluido), 32'd0);
    check("start_err_clr", 32'(ErroCarga), 32'd0);
  endtask

  task automatic run_load(input int unsigned max_gap);
    int unsigned waited;
    build_model();
    start_load();
    foreach (stream[k]) send_byte(stream[k], $urandom_range(0, max_gap));
    Iniciar    = 1'b0;
    ByteValido = 1'b0;
    check("acc_after_last", 32'(ByteAceito), 32'd0);
    check("busy_after_last", 32'(Ocupado), 32'(exp_ok));
    check("err_next_cycle", 32'(ErroCarga), 32'(!exp_ok));
    waited = 0;
    while (Ocupado && waited < 400) begin
      @(negedge Clock);
      waited++;
    end
    if (Ocupado) check("done_timeout", 32'(Ocupado), 32'd0);
    @(negedge Clock);
    check("n_writes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("write", 32'(got_q[i]), 32'(exp_q[i]));
    check("concluido", 32'(Concluido), 32'(exp_ok));
    check("erro", 32'(ErroCarga), 32'(!exp_ok));
    check("segurar", 32'(SegurarCPU), 32'(!exp_ok));
    check("ocupado_end", 32'(Ocupado), 32'd0);
    check("acc_end", 32'(ByteAceito), 32'd0);
    repeat (2) @(negedge Clock);
    check("final_held", 32'(Concluido), 32'(exp_ok));
  endtask

  task automatic good_stream();
    stream = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h61};
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_acc"}, 32'(ByteAceito), 32'd0);
    check({pfx, "_esc"}, 32'(EscInstr), 32'd0);
    check({pfx, "_end"}, 32'(EndInstr), 32'd0);
    check({pfx, "_dado"}, 32'(InstrEscrita), 32'd0);
    check({pfx, "_segurar"}, 32'(SegurarCPU), 32'd1);
    check({pfx, "_ocupado"}, 32'(Ocupado), 32'd0);
    check({pfx, "_concl"}, 32'(Concluido), 32'd0);
    check({pfx, "_erro"}, 32'(ErroCarga), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, s, c;
    Reset = 1'b1; Iniciar = 1'b0; ByteValido = 1'b0; ByteEntrada = '0;
    repeat (3) @(negedge Clock);
    check_reset_values("reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    good_stream();
    run_load(0);

    stream = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h60};
    run_load(0);

    stream = '{8'h00};
    run_load(0);

    good_stream();
    run_load(3);

    // Reset mid-DADOS, colliding with Iniciar and a valid byte.
    good_stream();
    start_load();
    for (int i = 0; i < 3; i++) send_byte(stream[i], 0);
    Reset = 1'b1; Iniciar = 1'b1; ByteValido = 1'b1; ByteEntrada = 8'h55;
    @(negedge Clock);
    Reset = 1'b0; Iniciar = 1'b0; ByteValido = 1'b0;
    check_reset_values("midreset");
    @(negedge Clock);
    check("midreset_no_pulse", 32'(EscInstr), 32'd0);
    check("midreset_idle", 32'(Ocupado), 32'd0);
    good_stream();
    run_load(1);

    stream.delete();
    stream.push_back(8'hFF);
    for (int i = 0; i < 255; i++) stream.push_back(8'h01);
    stream.push_back(8'h02);
    run_load(0);

    for (int unsigned it = 0; it < 6; it++) begin
      n = (it % 3 == 2) ? $urandom_range(200, 255) : $urandom_range(1, 30);
      stream.delete();
      stream.push_back(8'(n));
      s = n;
      for (int unsigned i = 0; i < n; i++) begin
        stream.push_back(8'($urandom_range(0, 255)));
        s = s + stream[i + 1];
      end
      c = (256 - (s % 256)) % 256;
      if ($urandom_range(0, 3) == 0) c = c ^ (32'd1 << $urandom_range(0, 7));
      stream.push_back(8'(c));
      run_load($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
